axi_simple_master: RTL and testbench

- Bridges a core-side request/stream interface (LSU / DMA) to an AXI4 master port.
- Sits directly upstream of the AXI-to-SRAM slave interface and drives its AW/W/B/AR/R channels.
- Issues one transaction at a time, in order: a single-word or INCR burst read or write.
- The slave supports neither out-of-order completion nor overlapped transactions, so this block keeps at most one outstanding transaction.

---
 rtl/axi_pkg.sv | 31 +++
 rtl/axi_beat_counter.sv | 36 +++
 rtl/axi_simple_master.sv | 210 +++++++++++++++++++++
 tb/tb_axi_simple_master.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the master FSM state type used by the
// simple master and its beat counter.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    DONE
  } mst_state_e;

  // EXOKAY also counts as an error: this master never issues exclusive accesses.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Burst beat counter: loads len+1 beats and counts down once per data
// handshake; reused by the SRAM slave front end.
module axi_beat_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] len_i,
  input  logic       dec_i,
  output logic       last_o,
  output logic       done_o
);

  logic [8:0] cnt_q, cnt_d;

  // Nine bits so len=255 loads 256 without wrapping to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = {1'b0, len_i} + 9'd1;
    end else if (dec_i && (cnt_q != 9'd0)) begin
      cnt_d = cnt_q - 9'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == 9'd1);
  assign done_o = (cnt_q == 9'd0);

endmodule

// File: rtl/axi_simple_master.sv
// AXI4 master bridge: turns one core-side request at a time into a single
// AXI read or write INCR burst and reports completion with an error flag.
module axi_simple_master
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID  = 4'h0,
  parameter logic [7:0] MAX_LEN = 8'd15
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_err,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWLOCK,
  output logic [3:0]  AWCACHE,
  output logic [2:0]  AWPROT,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARLOCK,
  output logic [3:0]  ARCACHE,
  output logic [2:0]  ARPROT,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  mst_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic        err_q, err_d;

  logic cnt_load, cnt_dec, cnt_last, cnt_done;

  axi_beat_counter u_beat_counter (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .load_i (cnt_load),
    .len_i  (req_len),
    .dec_i  (cnt_dec),
    .last_o (cnt_last),
    .done_o (cnt_done)
  );

  // IDs are ignored because only one transaction is ever outstanding.
  logic unused_inputs;
  assign unused_inputs = ^{BID, RID, cnt_done};

  assign AWID    = AXI_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;
  assign AWLOCK  = 1'b0;
  assign AWCACHE = 4'h0;
  assign AWPROT  = 3'h0;

  assign ARID    = AXI_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign ARLOCK  = 1'b0;
  assign ARCACHE = 4'h0;
  assign ARPROT  = 3'h0;

  assign WDATA = wdata;
  assign WSTRB = wstrb;
  assign rdata = RDATA;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    err_d       = err_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    req_ready   = 1'b0;
    ARVALID     = 1'b0;
    AWVALID     = 1'b0;
    WVALID      = 1'b0;
    WLAST       = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    RREADY      = 1'b0;
    BREADY      = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          len_d    = req_len;
          cnt_load = 1'b1;
          // Oversized bursts complete immediately with an error and never touch the bus.
          if (req_len > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = req_wr ? WR_ADDR : RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = RD_DATA;
      end

      RD_DATA: begin
        rdata_valid = RVALID;
        RREADY      = rdata_ready;
        rdata_last  = cnt_last & RVALID;
        if (RVALID && rdata_ready) begin
          cnt_dec = 1'b1;
          err_d   = err_q | resp_is_err(RRESP) | (RLAST != cnt_last);
          if (cnt_last) state_d = DONE;
        end
      end

      WR_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = WR_DATA;
      end

      WR_DATA: begin
        WVALID      = wdata_valid;
        wdata_ready = WREADY;
        WLAST       = cnt_last;
        if (wdata_valid && WREADY) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          err_d   = err_q | resp_is_err(BRESP);
          state_d = DONE;
        end
      end

      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_simple_master.sv
// Self-checking bench: a behavioural AXI slave plus a word-array reference
// memory, driven by a vector table, a reset sequence and random transactions.
module tb_axi_simple_master;

  localparam int MAXLEN = 15;
  localparam int BUDGET = 3000;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [31:0] rdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [3:0]  AWID, ARID, AWCACHE, ARCACHE, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWLOCK, ARLOCK, AWVALID, AWREADY, ARVALID, ARREADY;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY, BVALID, BREADY, RLAST, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi_simple_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    bit          wr;
    int          addr;
    int          len;
    logic [31:0] dbase;
    int          stall;
    logic [1:0]  bResp;
    logic [1:0]  rResp;
    bit          badLast;
    bit          toggle;
    bit          expErr;
  } vec_t;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] refMem [256];
  logic [31:0] slvMem [256];
  logic [31:0] curData [256];
  logic [31:0] wrData [$];

  bit curWr, curExpErr, badLast, rrToggle, togState;
  int curAddr, curLen, stallPct;
  logic [1:0] bRespInj, rRespInj;
  bit slvRdActive, slvWrActive, slvBPending, rHold, bHold;
  int slvRdAddr, slvRdLen, slvRdIdx, slvWrAddr, slvWrLen, slvWrIdx;
  int arCount, awCount, rBeats, wBeats;
  bit accepted, respSeen, txnDone, aborted;
  int cyc, cycleNo, acceptCycle, respCycle;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit rdy();
    return $urandom_range(0, 99) >= stallPct;
  endfunction

  function automatic vec_t mkVec(bit wr, int addr, int len, logic [31:0] dbase, int stall,
                                 logic [1:0] br, logic [1:0] rr, bit bl, bit tog, bit ee);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.dbase = dbase; v.stall = stall;
    v.bResp = br; v.rResp = rr; v.badLast = bl; v.toggle = tog; v.expErr = ee;
    return v;
  endfunction

  // Drives the core side and the slave side for one cycle (called at negedge).
  task automatic applyStimulus();
    if (!accepted) begin
      req_valid = 1'b1;
      req_wr    = curWr;
      req_addr  = 32'(curAddr);
      req_len   = 8'(curLen);
    end else begin
      req_valid = 1'($urandom_range(0, 1));
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_len   = 8'($urandom_range(0, 255));
    end
    AWREADY = rdy();
    ARREADY = rdy();
    WREADY  = rdy();
    if (slvRdActive) begin
      if (!rHold) RVALID = rdy();
      rHold = RVALID;
      RDATA = slvMem[(slvRdAddr + slvRdIdx) & 255];
      RLAST = (slvRdIdx == slvRdLen) ^ badLast;
      RRESP = rRespInj;
    end else begin
      RVALID = 1'b0; RDATA = $urandom; RLAST = 1'b0; RRESP = 2'b00;
    end
    if (slvBPending) begin
      if (!bHold) BVALID = rdy();
      bHold = BVALID;
      BRESP = bRespInj;
    end else begin
      BVALID = 1'b0; BRESP = 2'b00;
    end
    wdata_valid = (wrData.size() > 0) ? rdy() : 1'b0;
    wdata       = (wrData.size() > 0) ? wrData[0] : $urandom;
    wstrb       = 4'hF;
    if (rrToggle) begin
      rdata_ready = togState;
      togState    = ~togState;
    end else begin
      rdata_ready = rdy();
    end
    resp_ready = rdy();
  endtask

  // Observes one settled cycle, checks DUT outputs and advances the slave/model.
  task automatic evalCycle();
    cyc++;
    cycleNo++;
    if (!accepted) begin
      checkOutput("req_ready in idle", req_ready, 1);
      if (req_valid && req_ready) begin
        accepted    = 1'b1;
        acceptCycle = cycleNo;
      end
    end else if (!txnDone) begin
      checkOutput("req_ready while busy", req_ready, 0);
    end

    checkOutput("BREADY", BREADY, slvBPending);
    if (slvBPending && BVALID && BREADY) begin
      slvBPending = 1'b0;
      bHold       = 1'b0;
    end

    if (slvRdActive) begin
      checkOutput("rdata_valid passthru", rdata_valid, RVALID);
      checkOutput("RREADY passthru", RREADY, rdata_ready);
      checkOutput("rdata_last", rdata_last, RVALID && (slvRdIdx == curLen));
      if (RVALID) checkOutput("rdata passthru", rdata, RDATA);
      if (RVALID && RREADY) begin
        checkOutput("read data vs model", rdata, refMem[(curAddr + slvRdIdx) & 255]);
        rBeats++;
        slvRdIdx++;
        rHold = 1'b0;
        if (slvRdIdx > slvRdLen) slvRdActive = 1'b0;
      end
    end else begin
      checkOutput("RREADY outside read", RREADY, 0);
    end

    if (slvWrActive) begin
      checkOutput("WVALID passthru", WVALID, wdata_valid);
      checkOutput("wdata_ready passthru", wdata_ready, WREADY);
      if (WVALID) begin
        checkOutput("WDATA", WDATA, curData[slvWrIdx]);
        checkOutput("WLAST", WLAST, slvWrIdx == curLen);
        checkOutput("WSTRB", WSTRB, 4'hF);
      end
      if (WVALID && WREADY) begin
        slvMem[(slvWrAddr + slvWrIdx) & 255] = WDATA;
        wBeats++;
        slvWrIdx++;
        if (slvWrIdx > slvWrLen) begin
          slvWrActive = 1'b0;
          slvBPending = 1'b1;
        end
      end
    end else begin
      checkOutput("WVALID outside data phase", WVALID, 0);
    end
    if (wdata_valid && wdata_ready && wrData.size() > 0) void'(wrData.pop_front());

    if (ARVALID) begin
      checkOutput("ARVALID legal", (!curWr && curLen <= MAXLEN && arCount == 0), 1);
      checkOutput("ARADDR", ARADDR, 32'(curAddr));
      checkOutput("ARLEN", ARLEN, 8'(curLen));
      checkOutput("AR constants", {ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT},
                  {4'h0, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0});
      if (ARREADY) begin
        arCount++;
        slvRdActive = 1'b1; slvRdAddr = curAddr; slvRdLen = curLen; slvRdIdx = 0;
      end
    end
    if (AWVALID) begin
      checkOutput("AWVALID legal", (curWr && curLen <= MAXLEN && awCount == 0), 1);
      checkOutput("AWADDR", AWADDR, 32'(curAddr));
      checkOutput("AWLEN", AWLEN, 8'(curLen));
      checkOutput("AW constants", {AWID, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT},
                  {4'h0, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0});
      if (AWREADY) begin
        awCount++;
        slvWrActive = 1'b1; slvWrAddr = curAddr; slvWrLen = curLen; slvWrIdx = 0;
      end
    end

    if (resp_valid) begin
      checkOutput("resp only after burst", (slvRdActive || slvWrActive || slvBPending), 0);
      checkOutput("resp_err", resp_err, curExpErr);
      if (!respSeen) begin
        respSeen  = 1'b1;
        respCycle = cycleNo;
      end
      if (resp_ready) txnDone = 1'b1;
    end
  endtask

  task automatic runTxn(input vec_t v, input int resetBeat);
    bit valid;
    curWr = v.wr; curAddr = v.addr; curLen = v.len; stallPct = v.stall;
    bRespInj = v.bResp; rRespInj = v.rResp; badLast = v.badLast;
    rrToggle = v.toggle; curExpErr = v.expErr; togState = 1'b1;
    valid = (v.len <= MAXLEN);
    wrData.delete();
    for (int i = 0; i <= v.len; i++) begin
      curData[i] = v.dbase + 32'(i);
      if (v.wr && valid) begin
        refMem[(v.addr + i) & 255] = curData[i];
        wrData.push_back(curData[i]);
      end
    end
    slvRdActive = 0; slvWrActive = 0; slvBPending = 0; rHold = 0; bHold = 0;
    slvWrIdx = 0; slvRdIdx = 0;
    arCount = 0; awCount = 0; rBeats = 0; wBeats = 0;
    accepted = 0; respSeen = 0; txnDone = 0; cyc = 0;
    while (!txnDone && !aborted) begin
      @(negedge ACLK);
      applyStimulus();
      #1;
      evalCycle();
      if (resetBeat >= 0 && slvWrIdx >= resetBeat) return;
      if (cyc > BUDGET) begin
        checkOutput("transaction completes within budget", 0, 1);
        aborted = 1'b1;
      end
    end
    if (txnDone) begin
      checkOutput("AR count", arCount, (!v.wr && valid) ? 1 : 0);
      checkOutput("AW count", awCount, (v.wr && valid) ? 1 : 0);
      checkOutput("R beats", rBeats, (!v.wr && valid) ? v.len + 1 : 0);
      checkOutput("W beats", wBeats, (v.wr && valid) ? v.len + 1 : 0);
      if (valid) checkOutput("min accept-to-resp latency", (respCycle - acceptCycle) >= 3, 1);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vec_t rv;
    ARESET = 1'b1;
    req_valid = 0; req_wr = 0; req_addr = 0; req_len = 0;
    wdata_valid = 0; wdata = 0; wstrb = 0; rdata_ready = 0; resp_ready = 0;
    AWREADY = 0; ARREADY = 0; WREADY = 0; BID = 4'h5; RID = 4'hA;
    BRESP = 0; BVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    aborted = 0; cycleNo = 0; accepted = 0; txnDone = 0;
    for (int i = 0; i < 256; i++) begin
      refMem[i] = 32'h0;
      slvMem[i] = 32'h0;
    end

    repeat (3) @(negedge ACLK);
    #1;
    checkOutput("reset outputs low",
                {ARVALID, AWVALID, WVALID, BREADY, RREADY, resp_valid, resp_err, rdata_valid, rdata_last, wdata_ready}, 0);
    checkOutput("reset req_ready", req_ready, 1);
    @(negedge ACLK);
    ARESET = 1'b0;

    vecs.push_back(mkVec(1'b1, 'h10, 3, 32'hA0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b0, 'h10, 3, 32'h0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b0, 'h10, 3, 32'h0, 0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkVec(1'b1, 'h20, 0, 32'h5555_0000, 0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkVec(1'b0, 'h20, 0, 32'h0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b1, 'h30, 16, 32'h1, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkVec(1'b0, 'h30, 16, 32'h0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkVec(1'b0, 'h10, 1, 32'h0, 0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mkVec(1'b0, 'h10, 1, 32'h0, 0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mkVec(1'b1, 'h50, 15, 32'hBEEF_0000, 30, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b0, 'h50, 15, 32'h0, 30, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));

    foreach (vecs[i]) begin
      if (aborted) break;
      runTxn(vecs[i], -1);
    end

    // Reset in the middle of an 8-beat write, on its second data beat.
    if (!aborted) begin
      rv = mkVec(1'b1, 'hF0, 7, 32'h7700_0000, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      runTxn(rv, 1);
      @(negedge ACLK);
      applyStimulus();
      ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      checkOutput("VALIDs cleared by reset", {ARVALID, AWVALID, WVALID, BREADY, RREADY, resp_valid, resp_err}, 0);
      checkOutput("idle after reset edge", req_ready, 1);
      @(negedge ACLK);
      ARESET = 1'b0; req_valid = 0; wdata_valid = 0; RVALID = 0; BVALID = 0;
      slvWrActive = 0; slvBPending = 0; wrData.delete();
      repeat (6) begin
        @(negedge ACLK);
        #1;
        checkOutput("no completion after reset", resp_valid, 0);
        checkOutput("idle after reset", {req_ready, AWVALID, WVALID}, 3'b100);
      end
      runTxn(mkVec(1'b0, 'h10, 3, 32'h0, 10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0), -1);
    end

    for (int n = 0; n < 24 && !aborted; n++) begin
      vec_t r;
      r.wr      = 1'($urandom_range(0, 1));
      r.addr    = int'($urandom_range(0, 200));
      r.len     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 15));
      r.dbase   = $urandom;
      r.stall   = int'($urandom_range(0, 60));
      r.bResp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r.rResp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r.badLast = 1'b0;
      r.toggle  = 1'($urandom_range(0, 1));
      r.expErr  = (r.len > MAXLEN) || (r.wr ? (r.bResp != 2'b00) : (r.rResp != 2'b00));
      runTxn(r, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
